region_gesture_decoder: RTL and testbench

- Downstream of the four per-region colour trackers (0 red, 1 green, 2 yellow, 3 blue).
- Consumes their per-pixel detection flags plus the pixel scan position, and reduces them to one detection mask per frame.
- Debounces the mask across consecutive frames; emits a confirmed region code with a level-valid and a one-cycle event pulse for the game/control logic.

---
 rtl/gesture_pkg.sv | 25 ++
 rtl/frame_tick_gen.sv | 37 +++
 rtl/region_gesture_decoder.sv | 170 +++++++++++++++++
 tb/tb_region_gesture_decoder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared region codes, FSM state encoding and default frame geometry for the
// gesture decoder and other frame-rate logic.
package gesture_pkg;

    localparam logic [1:0] REG_RED    = 2'd0;
    localparam logic [1:0] REG_GREEN  = 2'd1;
    localparam logic [1:0] REG_YELLOW = 2'd2;
    localparam logic [1:0] REG_BLUE   = 2'd3;

    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CANDIDATE = 2'd1,
        CONFIRMED = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    // Frame counters stick at all-ones instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick on the first cycle the scan position reaches the last
// active pixel; holding that position does not retrigger.
module frame_tick_gen
    import gesture_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       tick
);

    logic [9:0] prev_x;
    logic [9:0] prev_y;
    logic       at_last;

    assign at_last = (x == 10'(WIDTH - 1)) && (y == 10'(HEIGHT - 1));
    assign tick    = enable && at_last && ((x != prev_x) || (y != prev_y));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_x <= '0;
            prev_y <= '0;
        end else if (!enable) begin
            prev_x <= '0;
            prev_y <= '0;
        end else begin
            prev_x <= x;
            prev_y <= y;
        end
    end

endmodule

// File: rtl/region_gesture_decoder.sv
// Reduces per-pixel region detections to one mask per frame and debounces it
// into a confirmed region code. Define STICKY_DETECT_EN to OR det over the frame.
//
// state     | meaning
// IDLE      | no region seen, nothing confirmed
// CANDIDATE | same single region seen cnt frames in a row
// CONFIRMED | region_id confirmed and still present
// RELEASE   | region_id missing for rcnt frames, still reported valid
module region_gesture_decoder
    import gesture_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int HEIGHT         = DEFAULT_HEIGHT,
    parameter int STABLE_FRAMES  = 3,
    parameter int RELEASE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [3:0] det,
    output logic [1:0] region_id,
    output logic       region_valid,
    output logic       region_pulse,
    output logic       ambiguous
);

    localparam logic [3:0] STABLE_CNT  = 4'(STABLE_FRAMES);
    localparam logic [3:0] RELEASE_CNT = 4'(RELEASE_FRAMES);

    logic       tick;
    logic [3:0] mask;
    logic       mask_single;
    logic       mask_multi;
    logic [1:0] mask_id;
    state_t     state;
    logic [1:0] cand;
    logic [3:0] cnt;
    logic [3:0] rcnt;
    logic [3:0] cnt_inc;
    logic [3:0] rcnt_inc;

    frame_tick_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .x      (x),
        .y      (y),
        .tick   (tick)
    );

`ifdef STICKY_DETECT_EN
    logic [3:0] det_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            det_acc <= '0;
        else if (!enable || tick)
            det_acc <= '0;
        else
            det_acc <= det_acc | det;
    end

    assign mask = det_acc | det;
`else
    assign mask = det;
`endif

    always_comb begin
        mask_single = 1'b1;
        mask_id     = REG_RED;
        case (mask)
            4'b0001: mask_id = REG_RED;
            4'b0010: mask_id = REG_GREEN;
            4'b0100: mask_id = REG_YELLOW;
            4'b1000: mask_id = REG_BLUE;
            default: mask_single = 1'b0;
        endcase
    end

    assign mask_multi = (mask != 4'b0000) && !mask_single;
    assign cnt_inc    = sat_inc(cnt);
    assign rcnt_inc   = sat_inc(rcnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            rcnt         <= '0;
            region_id    <= '0;
            region_valid <= 1'b0;
            region_pulse <= 1'b0;
            ambiguous    <= 1'b0;
        end else if (!enable) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            rcnt         <= '0;
            region_id    <= '0;
            region_valid <= 1'b0;
            region_pulse <= 1'b0;
            ambiguous    <= 1'b0;
        end else begin
            region_pulse <= 1'b0;
            if (tick) begin
                ambiguous <= mask_multi;
                case (state)
                    IDLE: begin
                        if (mask_single) begin
                            cand <= mask_id;
                            cnt  <= 4'd1;
                            if (STABLE_FRAMES == 1) begin
                                state        <= CONFIRMED;
                                region_id    <= mask_id;
                                region_valid <= 1'b1;
                                region_pulse <= 1'b1;
                            end else begin
                                state <= CANDIDATE;
                            end
                        end
                    end
                    CANDIDATE: begin
                        if (mask_single && mask_id == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == STABLE_CNT) begin
                                state        <= CONFIRMED;
                                region_id    <= cand;
                                region_valid <= 1'b1;
                                region_pulse <= 1'b1;
                            end
                        end else if (mask_single) begin
                            cand <= mask_id;
                            cnt  <= 4'd1;
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    CONFIRMED: begin
                        if (!(mask_single && mask_id == region_id)) begin
                            rcnt <= 4'd1;
                            if (RELEASE_FRAMES == 1) begin
                                state        <= IDLE;
                                region_valid <= 1'b0;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (mask_single && mask_id == region_id) begin
                            state <= CONFIRMED;
                            rcnt  <= '0;
                        end else if (rcnt_inc == RELEASE_CNT) begin
                            state        <= IDLE;
                            region_valid <= 1'b0;
                            rcnt         <= '0;
                        end else begin
                            rcnt <= rcnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_region_gesture_decoder.sv
// Self-checking bench for region_gesture_decoder: spec-derived frame vectors,
// hand-written corner sequences and randomized frames against a run-length model.
module tb_region_gesture_decoder;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int SF = 3;
    localparam int RF = 2;
`ifdef STICKY_DETECT_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [9:0] x   = '0;
    logic [9:0] y   = '0;
    logic [3:0] det = '0;
    logic [1:0] region_id;
    logic       region_valid;
    logic       region_pulse;
    logic       ambiguous;
    logic [4:0] outs;

    int checks = 0;
    int passes = 0;

    region_gesture_decoder #(
        .WIDTH(W), .HEIGHT(H), .STABLE_FRAMES(SF), .RELEASE_FRAMES(RF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (en),
        .x            (x),
        .y            (y),
        .det          (det),
        .region_id    (region_id),
        .region_valid (region_valid),
        .region_pulse (region_pulse),
        .ambiguous    (ambiguous)
    );

    always #5 clk = ~clk;
    assign outs = {region_id, region_valid, region_pulse, ambiguous};

    // Reference model: run lengths of identical single-region frames and of misses.
    int         m_prev_x, m_prev_y;
    logic [3:0] m_acc;
    logic [1:0] m_id;
    logic       m_valid, m_pulse, m_amb;
    int         run_id, run_len, miss_len;

    function automatic logic [4:0] m_outs();
        return {m_id, m_valid, m_pulse, m_amb};
    endfunction

    task automatic model_clear();
        m_prev_x = 0; m_prev_y = 0; m_acc = '0;
        m_id = '0; m_valid = 1'b0; m_pulse = 1'b0; m_amb = 1'b0;
        run_id = 0; run_len = 0; miss_len = 0;
    endtask

    task automatic model_frame(input logic [3:0] mask);
        int n;
        int id;
        n  = $countones(mask);
        id = 0;
        for (int b = 0; b < 4; b++) if (mask[b]) id = b;
        m_amb = (n > 1);
        if (!m_valid) begin
            if (n == 1) begin
                if (run_len > 0 && run_id == id) run_len++;
                else begin run_id = id; run_len = 1; end
                if (run_len >= SF) begin
                    m_valid = 1'b1; m_id = 2'(id); m_pulse = 1'b1;
                    run_len = 0; miss_len = 0;
                end
            end else begin
                run_len = 0;
            end
        end else if (n == 1 && id == int'(m_id)) begin
            miss_len = 0;
        end else begin
            miss_len++;
            if (miss_len >= RF) begin
                m_valid = 1'b0; run_len = 0; miss_len = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: id/valid/pulse/amb got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle, advance the model across the coming edge, check after it.
    task automatic step(input int cx, input int cy, input logic [3:0] cdet);
        logic       tk;
        logic [3:0] frame_or;
        x = 10'(cx); y = 10'(cy); det = cdet;
        if (rst || !en) begin
            model_clear();
        end else begin
            tk = (cx == W-1 && cy == H-1) && !(m_prev_x == cx && m_prev_y == cy);
            m_prev_x = cx; m_prev_y = cy;
            frame_or = m_acc | cdet;
            m_acc    = tk ? 4'b0 : frame_or;
            m_pulse  = 1'b0;
            if (tk) model_frame(STICKY ? frame_or : cdet);
        end
        @(negedge clk);
        check("model", outs, m_outs());
    endtask

    // One full scan; det_mid appears only at pixel mid_idx, det_tick at the last pixel.
    task automatic frame(input logic [3:0] det_tick, input logic [3:0] det_mid,
                         input int mid_idx, input int hold);
        for (int i = 0; i < W*H-1; i++)
            step(i % W, i / W, (i == mid_idx) ? det_mid : 4'b0000);
        for (int h = 0; h < hold; h++)
            step(W-1, H-1, det_tick);
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [1:0] id;
        logic       valid;
        logic       pulse;
        logic       amb;
    } vec_t;

    vec_t       vecs[24];
    logic [3:0] cur;
    logic [3:0] dmid;
    int         r;

    initial begin
        vecs[0]  = '{4'b0100, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0100, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b0000, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0001, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0001, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1000, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1000, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b1000, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b0010, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b0010, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'b0110, 2'd3, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{4'b0000, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{4'b0010, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{4'b0010, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{4'b0010, 2'd1, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{4'b0010, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[22] = '{4'b0000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[23] = '{4'b0000, 2'd1, 1'b0, 1'b0, 1'b0};

        model_clear();
        @(negedge clk);
        check("reset_state", outs, 5'b0);
        rst = 1'b0;
        en  = 1'b1;

        for (int i = 0; i < 24; i++) begin
            frame(vecs[i].mask, 4'b0000, -1, 1);
            check($sformatf("vec%0d", i), outs,
                  {vecs[i].id, vecs[i].valid, vecs[i].pulse, vecs[i].amb});
        end

        // Last pixel held five cycles counts as one frame.
        frame(4'b0001, 4'b0000, -1, 5);
        check("hold_one_tick", outs, {2'd1, 1'b0, 1'b0, 1'b0});
        frame(4'b0001, 4'b0000, -1, 1);
        check("hold_cnt2", outs, {2'd1, 1'b0, 1'b0, 1'b0});
        frame(4'b0001, 4'b0000, -1, 1);
        check("hold_cnt3_confirm", outs, {2'd0, 1'b1, 1'b1, 1'b0});
        frame(4'b0000, 4'b0000, -1, 1);
        frame(4'b0000, 4'b0000, -1, 1);
        check("hold_drop", outs, {2'd0, 1'b0, 1'b0, 1'b0});

        // Detection only in mid-frame.
        for (int i = 0; i < 3; i++) frame(4'b0000, 4'b0001, 5, 1);
        check("sticky_mid", outs, STICKY ? {2'd0, 1'b1, 1'b1, 1'b0} : 5'b0);

        rst = 1'b1;
        step(0, 0, 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) frame(4'b0100, 4'b0000, -1, 1);
        check("pre_rst_confirm", outs, {2'd2, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++) step(i % W, i / W, 4'b0010);
        #2 rst = 1'b1;
        #1 check("async_rst", outs, 5'b0);
        step(2, 1, 4'b0010);
        rst = 1'b0;

        en = 1'b0;
        frame(4'b0100, 4'b0000, -1, 1);
        check("disabled_f1", outs, 5'b0);
        frame(4'b0100, 4'b0000, -1, 1);
        check("disabled_f2", outs, 5'b0);
        en = 1'b1;

        frame(4'b0100, 4'b0000, -1, 1);
        frame(4'b0100, 4'b0000, -1, 1);
        check("abort_pre", outs, 5'b0);
        en = 1'b0;
        step(0, 0, 4'b0000);
        en = 1'b1;
        frame(4'b0100, 4'b0000, -1, 1);
        check("abort_restart1", outs, 5'b0);
        frame(4'b0100, 4'b0000, -1, 1);
        check("abort_restart2", outs, 5'b0);
        frame(4'b0100, 4'b0000, -1, 1);
        check("abort_confirm", outs, {2'd2, 1'b1, 1'b1, 1'b0});

        cur = 4'b0000;
        for (int f = 0; f < 200; f++) begin
            r = $urandom_range(0, 9);
            if (r >= 4 && r < 8) cur = 4'b0001 << $urandom_range(0, 3);
            else if (r == 8) cur = 4'b0000;
            else if (r == 9) cur = 4'($urandom_range(0, 15));
            dmid = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : cur;
            if ($urandom_range(0, 19) == 0) begin
                en = 1'b0;
                step(0, 0, 4'($urandom_range(0, 15)));
                en = 1'b1;
            end
            frame(cur, dmid, $urandom_range(0, W*H-2), $urandom_range(1, 3));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
